store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of store entries (power of two, 2..16).
REQ-002 The block SHALL have parameter AW, default 32, meaning the data-memory address width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-005 The block SHALL have port MemWrite, input, 1, core store request for the current cycle.
REQ-006 The block SHALL have port ALUResult, input, AW, core load/store byte address.
REQ-007 The block SHALL have port WriteData, input, 32, core store data, already lane-aligned.
REQ-008 The block SHALL have port Byte_Enable, input, 4, core store/load lane mask; bit i selects byte lane i.
REQ-009 The block SHALL have port ReadData, output, 32, load data returned to the core, with forwarding applied.
REQ-010 The block SHALL have port mem_raddr, output, AW, memory read address.
REQ-011 The block SHALL have port mem_rdata, input, 32, combinational memory read data for mem_raddr.
REQ-012 The block SHALL have port mem_wvalid, output, 1, write request to memory.
REQ-013 The block SHALL have port mem_wready, input, 1, memory accepts the write this cycle.
REQ-014 The block SHALL have ports mem_waddr (output, AW), mem_wdata (output, 32) and mem_wbe (output, 4), carrying the head entry.
REQ-015 The block SHALL have ports full (output, 1), empty (output, 1), count (output, clog2(DEPTH+1)) and overflow (output, 1, sticky drop flag).

Function
REQ-016 Push: the block SHALL capture {ALUResult, WriteData, Byte_Enable} at the tail on a rising edge when MemWrite=1 and Byte_Enable!=0; MemWrite with Byte_Enable=0 SHALL be ignored.
REQ-017 Pop: a handshake SHALL occur when mem_wvalid=1 and mem_wready=1; the head SHALL retire on that edge.
REQ-018 mem_wvalid SHALL equal !empty; mem_waddr/mem_wdata/mem_wbe SHALL be the head entry combinationally and held stable until the handshake.
REQ-019 Entries SHALL drain in strict FIFO order, one per handshake at most; adjacent stores SHALL NOT be merged.
REQ-020 count SHALL equal the number of valid entries, full SHALL be (count==DEPTH) and empty SHALL be (count==0), all registered-state derived.
REQ-021 Simultaneous push and pop SHALL leave count unchanged, including when full, because the retiring slot frees the space for the push.
REQ-022 Push when full without a pop in the same cycle SHALL drop the store, leave the contents unchanged, and set overflow=1 on that edge; overflow SHALL stay 1 until reset.
REQ-023 Pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or underflow.
REQ-024 mem_raddr SHALL equal ALUResult at all times.
REQ-025 Forwarding: for each lane i, ReadData[8i+7:8i] SHALL come from the youngest valid entry with addr[AW-1:2]==ALUResult[AW-1:2] and be[i]=1; if no entry matches, the lane SHALL come from mem_rdata.
REQ-026 The head entry SHALL participate in forwarding up to and including the cycle of its handshake.
REQ-027 A store being pushed in the current cycle SHALL NOT forward to a load in the same cycle.
REQ-028 ReadData SHALL be purely combinational, with zero latency from ALUResult, mem_rdata and stored state.

Reset
REQ-029 While rst=1, the block SHALL have all entries invalid, pointers=0, count=0, empty=1, full=0, overflow=0, mem_wvalid=0.
REQ-030 Reset asserted mid-drain SHALL discard all pending stores immediately, without waiting for the clock, and mem_wvalid SHALL fall asynchronously.
REQ-031 After rst deasserts, the first rising edge SHALL accept a push.

Verification
REQ-032 The bench SHALL cover store-then-drain: push addr 0x100, data 0xDEADBEEF, be 4'hF, with mem_wready=1 -> next cycle mem_wvalid=1 with the same fields; after the handshake, empty=1.
REQ-033 The bench SHALL cover fill and overflow: DEPTH=4, mem_wready=0, push 5 stores -> count=4, full=1, overflow=1, first 4 entries intact, 5th absent on drain.
REQ-034 The bench SHALL cover a full push-with-pop: full, mem_wready=1, MemWrite=1 in the same cycle -> count stays 4, overflow stays 0, new entry drained last.
REQ-035 The bench SHALL cover byte forwarding: buffer holds {0x200, 0x000000AA, be 4'h1} then {0x200, 0x0000BB00, be 4'h2}, mem_rdata=0x11223344, load 0x200 -> ReadData=0x1122BBAA.
REQ-036 The bench SHALL cover youngest-wins: two stores to 0x300, be 4'hF, data 0x1 then 0x2 -> load 0x300 returns 0x00000002; after the first retires, still 0x2.
REQ-037 The bench SHALL cover reset mid-operation: 3 entries pending, rst pulsed between clock edges -> immediately empty=1, mem_wvalid=0, count=0, overflow=0, and a load returns mem_rdata.

Source files
------------

// File: rtl/store_buffer.sv
// Store buffer between the core and data memory. Stores queue in FIFO order and drain
// through a valid/ready write port; loads see buffered bytes through youngest-wins forwarding.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         MemWrite,
    input  logic [AW-1:0]                ALUResult,
    input  logic [31:0]                  WriteData,
    input  logic [3:0]                   Byte_Enable,
    output logic [31:0]                  ReadData,
    output logic [AW-1:0]                mem_raddr,
    input  logic [31:0]                  mem_rdata,
    output logic                         mem_wvalid,
    input  logic                         mem_wready,
    output logic [AW-1:0]                mem_waddr,
    output logic [31:0]                  mem_wdata,
    output logic [3:0]                   mem_wbe,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [AW-1:0] addr_r [DEPTH];
    logic [31:0]   data_r [DEPTH];
    logic [3:0]    be_r   [DEPTH];
    logic [PW-1:0] head_r;
    logic [PW-1:0] tail_r;
    logic [CW-1:0] count_r;
    logic          overflow_r;

    logic          store_req_s;
    logic          empty_s;
    logic          full_s;
    logic          pop_s;
    logic          push_s;
    logic          drop_s;
    logic [31:0]   rd_s;

    assign store_req_s = MemWrite && (Byte_Enable != 4'b0000);
    assign empty_s     = (count_r == CW'(0));
    assign full_s      = (count_r == CW'(DEPTH));
    assign pop_s       = !empty_s && mem_wready;
    // A pop in the same cycle frees the slot, so a full buffer can still accept a push.
    assign push_s      = store_req_s && (!full_s || pop_s);
    assign drop_s      = store_req_s && full_s && !pop_s;

    // Pointer, occupancy and sticky overflow state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_r     <= {PW{1'b0}};
            tail_r     <= {PW{1'b0}};
            count_r    <= {CW{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                tail_r <= tail_r + PW'(1);
            end
            if (pop_s) begin
                head_r <= head_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Entry payload storage; validity is implied by head/count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            addr_r[tail_r] <= ALUResult;
            data_r[tail_r] <= WriteData;
            be_r[tail_r]   <= Byte_Enable;
        end
    end

    // Walk entries oldest to youngest so the youngest matching byte lane wins.
    always_comb begin : fwd
        logic [PW-1:0] idx;
        logic          hit;
        rd_s = mem_rdata;
        idx  = head_r;
        hit  = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_r + PW'(k);
            hit = (CW'(k) < count_r) && (addr_r[idx][AW-1:2] == ALUResult[AW-1:2]);
            for (int i = 0; i < 4; i++) begin
                rd_s[8*i +: 8] = (hit && be_r[idx][i]) ? data_r[idx][8*i +: 8] : rd_s[8*i +: 8];
            end
        end
    end

    assign ReadData   = rd_s;
    assign mem_raddr  = ALUResult;
    assign mem_wvalid = !empty_s;
    assign mem_waddr  = addr_r[head_r];
    assign mem_wdata  = data_r[head_r];
    assign mem_wbe    = be_r[head_r];
    assign full       = full_s;
    assign empty      = empty_s;
    assign count      = count_r;
    assign overflow   = overflow_r;

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios plus randomized traffic checked against a
// queue-based reference model of the buffer contents.
module tb_store_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 32;

    logic          clk;
    logic          rst;
    logic          MemWrite;
    logic [AW-1:0] ALUResult;
    logic [31:0]   WriteData;
    logic [3:0]    Byte_Enable;
    logic [31:0]   ReadData;
    logic [AW-1:0] mem_raddr;
    logic [31:0]   mem_rdata;
    logic          mem_wvalid;
    logic          mem_wready;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_wbe;
    logic          full;
    logic          empty;
    logic [2:0]    count;
    logic          overflow;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } st_t;

    st_t q[$];
    bit  m_ovf;
    int  n_checks = 0;
    int  n_errors = 0;

    store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .MemWrite(MemWrite), .ALUResult(ALUResult),
        .WriteData(WriteData), .Byte_Enable(Byte_Enable), .ReadData(ReadData),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .mem_wvalid(mem_wvalid),
        .mem_wready(mem_wready), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_wbe(mem_wbe), .full(full), .empty(empty), .count(count), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] r;
        r = rd;
        foreach (q[j]) begin
            if (q[j].addr[31:2] == a[31:2]) begin
                for (int i = 0; i < 4; i++) begin
                    if (q[j].be[i]) r[8*i +: 8] = q[j].data[8*i +: 8];
                end
            end
        end
        return r;
    endfunction

    task automatic check_outputs();
        check_eq("count", 64'(count), 64'(q.size()));
        check_eq("full", 64'(full), 64'(q.size() == DEPTH));
        check_eq("empty", 64'(empty), 64'(q.size() == 0));
        check_eq("wvalid", 64'(mem_wvalid), 64'(q.size() != 0));
        check_eq("overflow", 64'(overflow), 64'(m_ovf));
        check_eq("raddr", 64'(mem_raddr), 64'(ALUResult));
        if (q.size() > 0) begin
            check_eq("waddr", 64'(mem_waddr), 64'(q[0].addr));
            check_eq("wdata", 64'(mem_wdata), 64'(q[0].data));
            check_eq("wbe", 64'(mem_wbe), 64'(q[0].be));
        end
        check_eq("rdata", 64'(ReadData), 64'(model_rd(ALUResult, mem_rdata)));
    endtask

    task automatic model_update();
        int n;
        bit pop;
        bit req;
        n   = q.size();
        pop = (n > 0) && mem_wready;
        req = MemWrite && (Byte_Enable != 4'h0);
        if (pop) void'(q.pop_front());
        if (req) begin
            if ((n < DEPTH) || pop) q.push_back('{ALUResult, WriteData, Byte_Enable});
            else m_ovf = 1'b1;
        end
    endtask

    // Called just after a falling edge: drive, check mid-cycle, clock, update model.
    task automatic step(input logic mw, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, input logic wr, input logic [31:0] rdv);
        MemWrite    = mw;
        ALUResult   = a;
        WriteData   = wd;
        Byte_Enable = be;
        mem_wready  = wr;
        mem_rdata   = rdv;
        #1;
        check_outputs();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    // Reset pulse placed between clock edges; state must clear without any edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_eq("rst_count", 64'(count), 64'd0);
        check_eq("rst_empty", 64'(empty), 64'd1);
        check_eq("rst_full", 64'(full), 64'd0);
        check_eq("rst_ovf", 64'(overflow), 64'd0);
        check_eq("rst_wvalid", 64'(mem_wvalid), 64'd0);
        check_eq("rst_rdata", 64'(ReadData), 64'(mem_rdata));
        rst = 1'b0;
        q.delete();
        m_ovf = 1'b0;
    endtask

    initial begin
        MemWrite    = 1'b0;
        ALUResult   = 32'h0;
        WriteData   = 32'h0;
        Byte_Enable = 4'h0;
        mem_wready  = 1'b0;
        mem_rdata   = 32'hCAFEF00D;
        m_ovf       = 1'b0;
        do_reset();
        @(negedge clk);

        // Store then drain
        step(1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 1'b1, 32'h0);
        check_eq("s1_wvalid", 64'(mem_wvalid), 64'd1);
        check_eq("s1_waddr", 64'(mem_waddr), 64'h100);
        check_eq("s1_wdata", 64'(mem_wdata), 64'hDEADBEEF);
        check_eq("s1_wbe", 64'(mem_wbe), 64'hF);
        step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0);
        check_eq("s1_empty", 64'(empty), 64'd1);

        // Fill and overflow, then drain in order
        for (int k = 0; k < 5; k++)
            step(1'b1, 32'h10 * (k + 1), 32'hA0 + k, 4'hF, 1'b0, 32'h0);
        check_eq("s2_count", 64'(count), 64'd4);
        check_eq("s2_full", 64'(full), 64'd1);
        check_eq("s2_ovf", 64'(overflow), 64'd1);
        for (int k = 0; k < 4; k++) begin
            check_eq("s2_head", 64'(mem_wdata), 64'(32'hA0 + k));
            step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0);
        end
        check_eq("s2_empty", 64'(empty), 64'd1);
        do_reset();

        // Full with simultaneous push and pop
        for (int k = 0; k < 4; k++)
            step(1'b1, 32'h40 + 4 * k, 32'hB0 + k, 4'hF, 1'b0, 32'h0);
        step(1'b1, 32'h80, 32'hBEEF0034, 4'hF, 1'b1, 32'h0);
        check_eq("s3_count", 64'(count), 64'd4);
        check_eq("s3_full", 64'(full), 64'd1);
        check_eq("s3_ovf", 64'(overflow), 64'd0);
        for (int k = 0; k < 4; k++) begin
            check_eq("s3_head", 64'(mem_wdata), (k < 3) ? 64'(32'hB1 + k) : 64'hBEEF0034);
            step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0);
        end
        check_eq("s3_empty", 64'(empty), 64'd1);

        // Byte-lane forwarding
        step(1'b1, 32'h200, 32'h000000AA, 4'h1, 1'b0, 32'h0);
        step(1'b1, 32'h200, 32'h0000BB00, 4'h2, 1'b0, 32'h0);
        MemWrite  = 1'b0;
        ALUResult = 32'h200;
        mem_rdata = 32'h11223344;
        #1;
        check_eq("s4_fwd", 64'(ReadData), 64'h1122BBAA);

        // Youngest wins, also after the older match retires
        step(1'b1, 32'h300, 32'h1, 4'hF, 1'b0, 32'h0);
        step(1'b1, 32'h300, 32'h2, 4'hF, 1'b0, 32'h0);
        MemWrite  = 1'b0;
        ALUResult = 32'h300;
        mem_rdata = 32'h77777777;
        #1;
        check_eq("s5_young", 64'(ReadData), 64'h2);
        for (int k = 0; k < 3; k++)
            step(1'b0, 32'h300, 32'h0, 4'h0, 1'b1, 32'h99999999);
        check_eq("s5_count", 64'(count), 64'd1);
        MemWrite  = 1'b0;
        ALUResult = 32'h300;
        mem_rdata = 32'h77777777;
        #1;
        check_eq("s5_retired", 64'(ReadData), 64'h2);
        do_reset();

        // Reset mid-operation with three stores pending and overflow set
        for (int k = 0; k < 5; k++)
            step(1'b1, 32'h400 + 4 * k, 32'hC0 + k, 4'hF, 1'b0, 32'h0);
        step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0);
        check_eq("s6_count", 64'(count), 64'd3);
        check_eq("s6_ovf", 64'(overflow), 64'd1);
        MemWrite  = 1'b0;
        ALUResult = 32'h404;
        mem_rdata = 32'h55667788;
        #1;
        check_eq("s6_prefwd", 64'(ReadData), 64'hC1);
        do_reset();
        check_eq("s6_load", 64'(ReadData), 64'h55667788);

        // Randomized traffic against the model
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            step($urandom_range(0, 4) < 3,
                 32'h100 + 32'($urandom_range(0, 3)) * 32'h4 + 32'($urandom_range(0, 3)),
                 $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2) == 0, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
